gbsha_ttfir_param: RTL and testbench
====================================

Name: gbsha_ttfir_param

Overview:
Parametrised streaming FIR filter. Taps, sample width and output width are generic, and the block adds run-time configuration.
- After reset it accepts one config word, then N_TAPS coefficients, then filters samples under a valid/ready handshake.
- Output is either a scaled, saturated word (mode 0) or the full-precision sum split across two output words (mode 1).
- Drives the 8-bit chip output pins of the tile, next to the fixed 4-tap filter.

Parameters:
N_TAPS, 4, number of taps; must be >= 2.
BW_in, 6, sample and coefficient width, signed two's complement; must be >= 2.
BW_out, 8, output word width; 2*BW_out >= BW_sum is required (elaboration error otherwise).
BW_sum (derived, not overridable), 2*BW_in + clog2(N_TAPS), accumulator width (14 at defaults).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset: 0 = asserted, deassertion synchronous to clk
x_in  in  BW_in  config word, coefficient or sample (signed)
in_valid  in  1  x_in is valid
in_ready  out  1  block accepts x_in this cycle; transfer when in_valid & in_ready at rising edge
cfg_req  in  1  request return to configuration (sampled in RUN only)
y_out  out  BW_out  output word, registered
y_valid  out  1  y_out carries a new word this cycle
loaded  out  1  high in RUN state

Behaviour:
- Reset (async, reset=0): state=CFG, all coefficients and sample history = 0, shift=0, mode=0. Outputs: y_out=0, y_valid=0, loaded=0, in_ready=0 while asserted.
- Reset applies at any point, including mid-load and mid-output; no partial state survives.
- States: CFG -> COEF -> RUN; RUN -> RUN_LO (mode 1 only) -> RUN; RUN -> CFG on cfg_req.
- CFG:
  - in_ready=1.
  - On transfer: mode = x_in[0]; shift = x_in[BW_in-1:1] (unsigned, 0..2^(BW_in-1)-1).
  - Load counter = 0; go to COEF.
- COEF:
  - in_ready=1.
  - Each transfer shifts the coefficient register: coef[k] <= coef[k-1], coef[0] <= x_in.
  - After N_TAPS transfers go to RUN; the first word loaded ends in coef[N_TAPS-1].
  - No y_valid pulses in CFG or COEF.
- RUN:
  - in_ready = !cfg_req.
  - On sample transfer:
    - sum = x_in*coef[0] + sum over k of hist[k-1]*coef[k], k = 1..N_TAPS-1. Full precision BW_sum, signed, no overflow possible.
    - hist shifts: hist[0] <= x_in.
    - Output registered at the same edge; latency 1 cycle from transfer to y_valid.
- Mode 0:
  - y_out = sum >>> shift (arithmetic; shift >= BW_sum gives 0 or -1), saturated to signed BW_out range [-2^(BW_out-1), 2^(BW_out-1)-1].
  - y_valid=1 for one cycle per sample.
  - Back-to-back samples every cycle are allowed.
- Mode 1:
  - Shift is ignored; sum is sign-extended to 2*BW_out.
  - Edge of transfer: y_out = high word, y_valid=1, state -> RUN_LO.
  - RUN_LO: in_ready=0; next edge: y_out = low word, y_valid=1, state -> RUN.
  - Max throughput: one sample per 2 cycles.
- When y_valid=0, y_out holds its last value.
- cfg_req:
  - In RUN, if cfg_req=1 at an edge: no sample is accepted (in_ready is low); history cleared; state -> CFG.
  - In RUN_LO, the low word completes first and cfg_req is honoured on the following edge if still high.
  - Coefficients persist until overwritten by the new load.
  - cfg_req is ignored in CFG and COEF.
- in_valid=0 in any state: no state change except the RUN_LO completion.

Test Plan:
1. Impulse response. Config 0x00 (mode 0, shift 0); load coefficients 1,2,3,4; samples 1,0,0,0,0 back-to-back -> y_out 4,3,2,1,0. Each output appears 1 cycle after its sample, y_valid=1 each cycle, loaded=1 after the 4th coefficient.
2. Saturation. Config 0x00; load coefficients 0,0,0,-32; sample 31 -> sum -992 -> y_out 0x80 (-128). Sample -32 -> sum 1024 -> y_out 0x7F.
3. Scaling. Config 0x0A (shift 5, mode 0); coefficients 0,0,0,31; sample 31 -> y_out 30 (961>>>5). Sample -31 -> y_out 0xE1 (-31, floor).
4. Split output. Config 0x01 (mode 1); coefficients 0,0,0,-32; sample -32 -> y_out 0x04 then 0x00 on consecutive cycles with y_valid=1 both cycles, and in_ready=0 in the second cycle. Sample 1 -> 0xFF then 0xE0.
5. Async reset mid-load. Assert reset=0 between clock edges after 2 coefficients -> y_out=0, y_valid=0, loaded=0 immediately, without a clock edge. A full reload plus the scenario 1 stimulus reproduces scenario 1 exactly.
6. Reconfigure. In RUN, mode 0, with non-zero history, raise cfg_req with in_valid=1 -> in_ready=0, that sample is not consumed, state = CFG. Reload config 0x00 with coefficients 1,2,3,4 and an impulse -> outputs 4,3,2,1, proving the history was cleared.

Source files
------------

// File: rtl/gbsha_ttfir_param.sv
// gbsha_ttfir_param -- run-time configurable streaming FIR filter.
//
// After reset the block takes one config word, then N_TAPS coefficients,
// then filters a stream of signed samples.
//
// Config word: bit 0 = output mode, bits [BW_in-1:1] = right shift.
//   mode 0: y_out = saturate(sum >>> shift), one word per sample.
//   mode 1: the full-precision sum, sign-extended to 2*BW_out, is sent as
//           the high word followed by the low word on the next cycle.
//
// Handshake: a word on x_in transfers on a rising clk edge where
// in_valid & in_ready are both high. in_ready depends only on state, cfg_req
// and reset, never on in_valid. y_valid is a one-cycle pulse per output word.
// y_out holds its last value while y_valid is low.
//
// Ports:
//   clk       clock, every state update on the rising edge
//   reset     asynchronous active-low reset
//   x_in      config word, coefficient or sample (signed)
//   in_valid  x_in carries a word
//   in_ready  block accepts x_in this cycle
//   cfg_req   request a return to configuration (acted on in RUN only)
//   y_out     registered output word
//   y_valid   y_out carries a new word this cycle
//   loaded    coefficients are loaded and the filter is running
//
// The current FSM state is held in the enum signal 'state' so that checkers
// can bind to it.

module gbsha_ttfir_param #(
    parameter int N_TAPS = 4,
    parameter int BW_in  = 6,
    parameter int BW_out = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BW_in-1:0]  x_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cfg_req,
    output logic [BW_out-1:0] y_out,
    output logic              y_valid,
    output logic              loaded
);

    // Accumulator width: one full product plus growth for N_TAPS terms.
    localparam int BW_sum = 2 * BW_in + $clog2(N_TAPS);
    // Comparison width for saturation. It is wide enough to hold both the
    // sum and the BW_out limits with a spare sign bit.
    localparam int BW_w   = ((BW_sum > BW_out) ? BW_sum : BW_out) + 1;
    localparam int CNT_W  = $clog2(N_TAPS) + 1;
    localparam int SH_W   = BW_in - 1;

    localparam logic signed [BW_w-1:0] SAT_MAX =
        {{(BW_w - BW_out + 1){1'b0}}, {(BW_out - 1){1'b1}}};
    localparam logic signed [BW_w-1:0] SAT_MIN = ~SAT_MAX;

    generate
        if (N_TAPS < 2) begin : g_bad_taps
            $error("gbsha_ttfir_param: N_TAPS must be >= 2");
        end
        if (BW_in < 2) begin : g_bad_bw_in
            $error("gbsha_ttfir_param: BW_in must be >= 2");
        end
        if (2 * BW_out < BW_sum) begin : g_bad_bw_out
            $error("gbsha_ttfir_param: 2*BW_out must be >= BW_sum");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_CFG    = 2'd0,
        ST_COEF   = 2'd1,
        ST_RUN    = 2'd2,
        ST_RUN_LO = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic                     xfer;
    logic signed [BW_in-1:0]  x_s;

    logic signed [BW_in-1:0]  coef [N_TAPS];
    // hist[k] is the sample accepted k+1 transfers ago.
    logic signed [BW_in-1:0]  hist [N_TAPS-1];
    logic [SH_W-1:0]          shift;
    logic                     mode;
    logic [CNT_W-1:0]         cnt;
    logic [BW_out-1:0]        lo_word;

    logic signed [BW_sum-1:0]   sum;
    logic signed [BW_sum-1:0]   shifted;
    logic signed [BW_w-1:0]     shifted_w;
    logic [BW_out-1:0]          y_sat;
    logic signed [2*BW_out-1:0] full;
    logic [BW_out-1:0]          hi_part;
    logic [BW_out-1:0]          lo_part;

    assign x_s  = x_in;
    assign xfer = in_valid & in_ready;

    // Signed product at accumulator width. Both operands are sign-extended
    // first, so the truncated BW_sum result is exact.
    function automatic logic signed [BW_sum-1:0] mul_ext(
        input logic signed [BW_in-1:0] a,
        input logic signed [BW_in-1:0] b
    );
        logic signed [BW_sum-1:0] ae;
        logic signed [BW_sum-1:0] be;
        ae = BW_sum'(a);
        be = BW_sum'(b);
        return ae * be;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_CFG;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_CFG: begin
                if (xfer) begin
                    state_next = ST_COEF;
                end
            end
            ST_COEF: begin
                if (xfer && (cnt == CNT_W'(N_TAPS - 1))) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // in_ready is low while cfg_req is high, so the request can
                // never collide with an accepted sample.
                if (cfg_req) begin
                    state_next = ST_CFG;
                end else if (xfer && mode) begin
                    state_next = ST_RUN_LO;
                end
            end
            ST_RUN_LO: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_CFG;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        loaded   = 1'b0;
        case (state)
            ST_CFG:    in_ready = 1'b1;
            ST_COEF:   in_ready = 1'b1;
            ST_RUN: begin
                in_ready = ~cfg_req;
                loaded   = 1'b1;
            end
            ST_RUN_LO: loaded   = 1'b1;
            default: begin
                in_ready = 1'b0;
                loaded   = 1'b0;
            end
        endcase
        // The state register already reads CFG during reset. Gating in_ready
        // as well keeps it low for the whole time reset is held.
        if (!reset) begin
            in_ready = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: filter sum and the two output formats
    // ------------------------------------------------------------------
    always_comb begin
        sum = mul_ext(x_s, coef[0]);
        for (int k = 1; k < N_TAPS; k++) begin
            sum = sum + mul_ext(hist[k-1], coef[k]);
        end
    end

    always_comb begin
        // An arithmetic shift by BW_sum or more leaves only sign bits,
        // which gives 0 or -1.
        shifted   = sum >>> shift;
        shifted_w = BW_w'(shifted);
        if (shifted_w > SAT_MAX) begin
            y_sat = SAT_MAX[BW_out-1:0];
        end else if (shifted_w < SAT_MIN) begin
            y_sat = SAT_MIN[BW_out-1:0];
        end else begin
            y_sat = shifted_w[BW_out-1:0];
        end
    end

    always_comb begin
        full    = (2 * BW_out)'(sum);
        hi_part = full[2*BW_out-1:BW_out];
        lo_part = full[BW_out-1:0];
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                coef[k] <= '0;
            end
            for (int k = 0; k < N_TAPS - 1; k++) begin
                hist[k] <= '0;
            end
            shift   <= '0;
            mode    <= 1'b0;
            cnt     <= '0;
            lo_word <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                ST_CFG: begin
                    if (xfer) begin
                        mode  <= x_in[0];
                        shift <= x_in[BW_in-1:1];
                        cnt   <= '0;
                    end
                end
                ST_COEF: begin
                    // Coefficients shift in, so the first word loaded ends
                    // up in coef[N_TAPS-1].
                    if (xfer) begin
                        coef[0] <= x_s;
                        for (int k = 1; k < N_TAPS; k++) begin
                            coef[k] <= coef[k-1];
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cfg_req) begin
                        // Only the history is cleared. The coefficients stay
                        // until the next load overwrites them.
                        for (int k = 0; k < N_TAPS - 1; k++) begin
                            hist[k] <= '0;
                        end
                    end else if (xfer) begin
                        hist[0] <= x_s;
                        for (int k = 1; k < N_TAPS - 1; k++) begin
                            hist[k] <= hist[k-1];
                        end
                        y_valid <= 1'b1;
                        if (mode) begin
                            y_out   <= hi_part;
                            lo_word <= lo_part;
                        end else begin
                            y_out <= y_sat;
                        end
                    end
                end
                ST_RUN_LO: begin
                    y_out   <= lo_word;
                    y_valid <= 1'b1;
                end
                default: begin
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gbsha_ttfir_param.sv
// tb_gbsha_ttfir_param -- directed self-checking bench for gbsha_ttfir_param
// at its default parameters (N_TAPS=4, BW_in=6, BW_out=8).
// Inputs change on the falling edge. Outputs are sampled 1 time unit after
// the rising edge.

module tb_gbsha_ttfir_param;

    logic       clk;
    logic       reset;
    logic [5:0] x_in;
    logic       in_valid;
    logic       in_ready;
    logic       cfg_req;
    logic [7:0] y_out;
    logic       y_valid;
    logic       loaded;

    int checks;
    int errors;

    gbsha_ttfir_param #(
        .N_TAPS (4),
        .BW_in  (6),
        .BW_out (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x_in     (x_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_req  (cfg_req),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .loaded   (loaded)
    );

    // ------------------------------------------------------------------
    // Clock and watchdog
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        cfg_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Present one word, wait (bounded) for in_ready, and return 1 time unit
    // after the transfer edge.
    task automatic send(input int v);
        int n;
        @(negedge clk);
        x_in = v[5:0];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input int cfg, input int c0, input int c1,
                        input int c2, input int c3);
        send(cfg);
        send(c0);
        send(c1);
        send(c2);
        send(c3);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        x_in = '0;
        in_valid = 1'b0;
        cfg_req = 1'b0;
        #12;
        checks++;
        if (y_out !== 8'h00) begin errors++; $display("FAIL reset_y_out: got %h required 00", y_out); end
        checks++;
        if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b required 0", y_valid); end
        checks++;
        if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b required 0", loaded); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL cfg_in_ready: got %b required 1", in_ready); end
    endtask

    // Config 0x00, coefficients 1,2,3,4, impulse back-to-back -> 4,3,2,1,0.
    task automatic test_impulse(input string tag);
        int          s [5];
        logic [7:0]  e [5];
        s = '{1, 0, 0, 0, 0};
        e = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        load(0, 1, 2, 3, 4);
        checks++;
        if (loaded !== 1'b1) begin errors++; $display("FAIL %s_loaded: got %b required 1", tag, loaded); end
        checks++;
        if (y_valid !== 1'b0) begin errors++; $display("FAIL %s_no_valid_in_load: got %b required 0", tag, y_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x_in = s[i][5:0];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (y_valid !== 1'b1 || y_out !== e[i]) begin
                errors++;
                $display("FAIL %s_out%0d: got valid=%b y=%h required valid=1 y=%h", tag, i, y_valid, y_out, e[i]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (y_valid !== 1'b0) begin errors++; $display("FAIL %s_idle_valid: got %b required 0", tag, y_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        load(0, 0, 0, 0, -32);
        send(31);
        checks++;
        if (y_out !== 8'h80 || y_valid !== 1'b1) begin errors++; $display("FAIL sat_neg: got y=%h valid=%b required y=80 valid=1", y_out, y_valid); end
        send(-32);
        checks++;
        if (y_out !== 8'h7F || y_valid !== 1'b1) begin errors++; $display("FAIL sat_pos: got y=%h valid=%b required y=7f valid=1", y_out, y_valid); end
    endtask

    task automatic test_scaling();
        do_reset();
        load(8'h0A, 0, 0, 0, 31);
        send(31);
        checks++;
        if (y_out !== 8'd30) begin errors++; $display("FAIL scale_pos: got %h required 1e", y_out); end
        send(-31);
        checks++;
        if (y_out !== 8'hE1) begin errors++; $display("FAIL scale_neg_floor: got %h required e1", y_out); end
    endtask

    task automatic test_split();
        do_reset();
        load(1, 0, 0, 0, -32);
        send(-32);
        checks++;
        if (y_out !== 8'h04 || y_valid !== 1'b1) begin errors++; $display("FAIL split1_hi: got y=%h valid=%b required y=04 valid=1", y_out, y_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL split1_lo_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (y_out !== 8'h00 || y_valid !== 1'b1) begin errors++; $display("FAIL split1_lo: got y=%h valid=%b required y=00 valid=1", y_out, y_valid); end
        send(1);
        checks++;
        if (y_out !== 8'hFF || y_valid !== 1'b1) begin errors++; $display("FAIL split2_hi: got y=%h valid=%b required y=ff valid=1", y_out, y_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (y_out !== 8'hE0 || y_valid !== 1'b1) begin errors++; $display("FAIL split2_lo: got y=%h valid=%b required y=e0 valid=1", y_out, y_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (y_valid !== 1'b0 || y_out !== 8'hE0) begin errors++; $display("FAIL split_hold: got y=%h valid=%b required y=e0 valid=0", y_out, y_valid); end
    endtask

    task automatic test_async_reset();
        // Leave RUN through cfg_req, start a new load, then reset mid-load.
        @(negedge clk);
        cfg_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (loaded !== 1'b0) begin errors++; $display("FAIL reload_loaded: got %b required 0", loaded); end
        cfg_req = 1'b0;
        send(0);
        send(1);
        send(2);
        checks++;
        if (y_out !== 8'hE0) begin errors++; $display("FAIL midload_hold: got %h required e0", y_out); end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (y_out !== 8'h00 || y_valid !== 1'b0 || loaded !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got y=%h valid=%b loaded=%b ready=%b required 00 0 0 0", y_out, y_valid, loaded, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        test_impulse("after_reset");
    endtask

    task automatic test_reconfigure();
        send(5);
        checks++;
        if (y_out !== 8'd20) begin errors++; $display("FAIL hist_s1: got %h required 14", y_out); end
        send(7);
        checks++;
        if (y_out !== 8'd43) begin errors++; $display("FAIL hist_s2: got %h required 2b", y_out); end
        @(negedge clk);
        cfg_req = 1'b1;
        in_valid = 1'b1;
        x_in = 6'd9;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_req_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (y_valid !== 1'b0 || loaded !== 1'b0) begin
            errors++;
            $display("FAIL cfg_req_not_consumed: got valid=%b loaded=%b required 0 0", y_valid, loaded);
        end
        @(negedge clk);
        cfg_req = 1'b0;
        in_valid = 1'b0;
        test_impulse("after_cfg_req");
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_impulse("impulse");
        test_saturation();
        test_scaling();
        test_split();
        test_async_reset();
        test_reconfigure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
